// File: rtl/noc_packetizer.sv
// noc_packetizer: packs local payloads into {type, dest, src, data} packets, queues them in a
// small FIFO and sends each over a 4-phase req/ack channel. Define NOC_PKT_STATS_EN for pkt_sent_cnt.
module noc_packetizer #(
    parameter int         WIDTH       = 47,
    parameter logic [2:0] SRC_ADDR    = 3'b000,
    parameter int         DEPTH       = 4,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_type,
    input  logic [2:0]             in_dest,
    input  logic [39:0]            in_data,
    output logic                   pkt_req,
    output logic [WIDTH-1:0]       pkt_data,
    input  logic                   pkt_ack,
    output logic [$clog2(DEPTH):0] fifo_count
`ifdef NOC_PKT_STATS_EN
    ,
    output logic [15:0]            pkt_sent_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        RST_WAIT,
        IDLE,
        SETUP,
        REQ,
        REL
    } state_t;

    logic [1:0]             rst_sync_q, rst_sync_d;
    logic                   rst_int_n;
    logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
    logic                   ack_s;

    state_t                 state_q, state_d;
    logic                   pkt_req_q, pkt_req_d;
    logic [WIDTH-1:0]       pkt_data_q, pkt_data_d;

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [WIDTH-1:0]       mem_d [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic                   push;
    logic                   pop;
    logic [WIDTH-1:0]       entry;

    // Reset asserts asynchronously but releases only on a clock edge.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= rst_sync_d;
    end

    assign rst_int_n = rst_sync_q[1];

    // Synchroniser resets to "ack high" so RST_WAIT only exits once a real low has crossed over.
    always_comb begin
        ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], pkt_ack};
    end

    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    assign entry    = {in_type, in_dest, SRC_ADDR, in_data};
    assign in_ready = (state_q != RST_WAIT) && (count_q != CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        pkt_req_d  = pkt_req_q;
        pkt_data_d = pkt_data_q;
        pop        = 1'b0;
        case (state_q)
            RST_WAIT: if (!ack_s) state_d = IDLE;
            IDLE: begin
                if (count_q != '0) begin
                    pkt_data_d = mem_q[rd_ptr_q];
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                pkt_req_d = 1'b1;
                state_d   = REQ;
            end
            REQ: begin
                if (ack_s) begin
                    pkt_req_d = 1'b0;
                    state_d   = REL;
                end
            end
            REL: begin
                if (!ack_s) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = RST_WAIT;
        endcase
    end

    // The head entry stays in the FIFO until its full handshake has completed.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            ack_sync_q <= '1;
            state_q    <= RST_WAIT;
            pkt_req_q  <= 1'b0;
            pkt_data_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            ack_sync_q <= ack_sync_d;
            state_q    <= state_d;
            pkt_req_q  <= pkt_req_d;
            pkt_data_q <= pkt_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    assign pkt_req    = pkt_req_q;
    assign pkt_data   = pkt_data_q;
    assign fifo_count = count_q;

`ifdef NOC_PKT_STATS_EN
    logic [15:0] sent_cnt_q, sent_cnt_d;

    always_comb begin
        sent_cnt_d = sent_cnt_q;
        if (pop) sent_cnt_d = sent_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) sent_cnt_q <= '0;
        else            sent_cnt_q <= sent_cnt_d;
    end

    assign pkt_sent_cnt = sent_cnt_q;
`endif

endmodule
